// File: rtl/exc_pipe_ctrl.sv
// Exception sequencer for the 5-stage MIPS pipeline.
// Carries each instruction's ExcCode from D to M; the earliest detected code wins.
// Commits exceptions, interrupts and ERET in M.
// Drives flush, PC redirect and EPC/EXL control toward CP0.
module exc_pipe_ctrl #(
    parameter int                CODE_W   = 5,
    parameter logic [CODE_W-1:0] INT_CODE = '0,
    parameter logic [CODE_W-1:0] RI_CODE  = CODE_W'(10)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_vld,
    input  logic [CODE_W-1:0] exc_F,
    input  logic [CODE_W-1:0] exc_D,
    input  logic [CODE_W-1:0] exc_E,
    input  logic              eret_M,
    input  logic              int_pend,
    output logic              flush,
    output logic              exc_take,
    output logic [CODE_W-1:0] exc_code,
    output logic              epc_we,
    output logic              eret_take,
    output logic              redirect,
    output logic              redir_epc,
    output logic              exl
);

    localparam logic STATE_RUN = 1'b0;
    localparam logic STATE_EXL = 1'b1;

    logic [CODE_W-1:0] code_d_q, code_d_d;
    logic [CODE_W-1:0] code_e_q, code_e_d;
    logic [CODE_W-1:0] code_m_q, code_m_d;
    logic              vld_d_q, vld_d_d;
    logic              vld_e_q, vld_e_d;
    logic              vld_m_q, vld_m_d;
    logic              state_q, state_d;

    logic              int_hit;
    logic              sync_hit;
    logic              bad_eret;
    logic              take;
    logic              eret_hit;

    // Commit decision for the instruction in M; bubbles never commit anything.
    always_comb begin
        int_hit  = vld_m_q & int_pend & (state_q == STATE_RUN);
        sync_hit = vld_m_q & (code_m_q != '0);
        bad_eret = vld_m_q & eret_M & (state_q == STATE_RUN) & ~sync_hit;
        take     = int_hit | sync_hit | bad_eret;
        eret_hit = vld_m_q & eret_M & (state_q == STATE_EXL) & ~sync_hit & ~int_hit;

        // Interrupt outranks a synchronous code; a synchronous code outranks the ERET itself.
        exc_code = '0;
        if (int_hit) begin
            exc_code = INT_CODE;
        end else if (sync_hit) begin
            exc_code = code_m_q;
        end else if (bad_eret) begin
            exc_code = RI_CODE;
        end

        exc_take  = take;
        epc_we    = take & (state_q == STATE_RUN);
        eret_take = eret_hit;
        flush     = take | eret_hit;
        redirect  = take | eret_hit;
        redir_epc = eret_hit;
        exl       = (state_q == STATE_EXL);
    end

    // Stage advance: flush empties everything and beats stall; stall holds D and bubbles E.
    always_comb begin
        code_d_d = exc_F;
        vld_d_d  = fetch_vld;
        code_e_d = (code_d_q != '0) ? code_d_q : exc_D;
        vld_e_d  = vld_d_q;
        code_m_d = (code_e_q != '0) ? code_e_q : exc_E;
        vld_m_d  = vld_e_q;
        if (flush) begin
            code_d_d = '0;
            vld_d_d  = 1'b0;
            code_e_d = '0;
            vld_e_d  = 1'b0;
            code_m_d = '0;
            vld_m_d  = 1'b0;
        end else if (stall) begin
            code_d_d = code_d_q;
            vld_d_d  = vld_d_q;
            code_e_d = '0;
            vld_e_d  = 1'b0;
        end
    end

    // Handler state: any take enters (or stays in) EXL, a committed ERET returns to RUN.
    always_comb begin
        state_d = state_q;
        if (take) begin
            state_d = STATE_EXL;
        end else if (eret_hit) begin
            state_d = STATE_RUN;
        end
    end

    // State registers with synchronous reset that discards every pending code.
    always_ff @(posedge clk) begin
        if (reset) begin
            code_d_q <= '0;
            code_e_q <= '0;
            code_m_q <= '0;
            vld_d_q  <= 1'b0;
            vld_e_q  <= 1'b0;
            vld_m_q  <= 1'b0;
            state_q  <= STATE_RUN;
        end else begin
            code_d_q <= code_d_d;
            code_e_q <= code_e_d;
            code_m_q <= code_m_d;
            vld_d_q  <= vld_d_d;
            vld_e_q  <= vld_e_d;
            vld_m_q  <= vld_m_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: tb/tb_exc_pipe_ctrl.sv
// Directed bench for exc_pipe_ctrl: expected commit events are queued when the
// stimulus is driven and matched against the DUT when flush/take/eret appear.
module tb_exc_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       fetch_vld = 1'b0;
    logic [4:0] exc_F = '0;
    logic [4:0] exc_D = '0;
    logic [4:0] exc_E = '0;
    logic       eret_M = 1'b0;
    logic       int_pend = 1'b0;
    logic       flush;
    logic       exc_take;
    logic [4:0] exc_code;
    logic       epc_we;
    logic       eret_take;
    logic       redirect;
    logic       redir_epc;
    logic       exl;

    exc_pipe_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .fetch_vld (fetch_vld),
        .exc_F     (exc_F),
        .exc_D     (exc_D),
        .exc_E     (exc_E),
        .eret_M    (eret_M),
        .int_pend  (int_pend),
        .flush     (flush),
        .exc_take  (exc_take),
        .exc_code  (exc_code),
        .epc_we    (epc_we),
        .eret_take (eret_take),
        .redirect  (redirect),
        .redir_epc (redir_epc),
        .exl       (exl)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       eret;
        logic [4:0] code;
        logic       epc;
    } ev_t;

    ev_t sb[$];
    ev_t mon_ev;
    int  n_asserts = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_take(input int at, input logic [4:0] code, input logic epc);
        ev_t e;
        e.cyc = at; e.eret = 1'b0; e.code = code; e.epc = epc;
        sb.push_back(e);
    endtask

    task automatic push_eret(input int at);
        ev_t e;
        e.cyc = at; e.eret = 1'b1; e.code = '0; e.epc = 1'b0;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: samples mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        #2;
        if (cyc > 0) begin
            if (exc_take === 1'b1 || eret_take === 1'b1 || flush === 1'b1 || redirect === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_take", exc_take, 0);
                    chk("unexpected_eret", eret_take, 0);
                    chk("unexpected_flush", flush, 0);
                end else begin
                    mon_ev = sb.pop_front();
                    chk("ev_cycle", cyc, mon_ev.cyc);
                    chk("ev_exc_take", exc_take, !mon_ev.eret);
                    chk("ev_eret_take", eret_take, mon_ev.eret);
                    chk("ev_redir_epc", redir_epc, mon_ev.eret);
                    chk("ev_flush", flush, 1);
                    chk("ev_redirect", redirect, 1);
                    chk("ev_epc_we", epc_we, mon_ev.epc);
                    if (!mon_ev.eret) chk("ev_exc_code", exc_code, mon_ev.code);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                chk("event_present", flush, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic fv, input logic [4:0] ef, input logic [4:0] ed,
                        input logic [4:0] ee, input logic st, input logic er, input logic ip);
        @(negedge clk);
        fetch_vld = fv; exc_F = ef; exc_D = ed; exc_E = ee;
        stall = st; eret_M = er; int_pend = ip;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_eret();
        int t;
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        t = cyc;
        idle(2);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        push_eret(t + 3);
        idle(1);
        #3;
        chk("exl_after_eret", exl, 0);
    endtask

    int t;

    initial begin
        // Reset state
        idle(2);
        reset = 1'b0;
        #3;
        chk("rst_flush", flush, 0);
        chk("rst_exc_take", exc_take, 0);
        chk("rst_exc_code", exc_code, 0);
        chk("rst_epc_we", epc_we, 0);
        chk("rst_eret_take", eret_take, 0);
        chk("rst_redirect", redirect, 0);
        chk("rst_redir_epc", redir_epc, 0);
        chk("rst_exl", exl, 0);

        // T1: exc_F=4 commits 3 cycles later; younger faulting instrs are flushed even under stall
        step(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        t = cyc;
        push_take(t + 3, 5'd4, 1'b1);
        step(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #3;
        chk("t1_exl_commit_cycle", exl, 0);
        idle(1);
        #3;
        chk("t1_exl_after", exl, 1);
        idle(3);
        do_eret();

        // T2: F code 4 and E code 12 on the same instr -> 4
        step(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        t = cyc;
        push_take(t + 3, 5'd4, 1'b1);
        idle(1);
        step(1'b0, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Sync exception inside EXL: taken, no EPC write, stays in EXL
        step(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        t = cyc;
        push_take(t + 3, 5'd8, 1'b0);
        idle(3);
        idle(1);
        #3;
        chk("exl_sync_stays", exl, 1);

        // Sync code on an ERET in EXL beats the ERET
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        t = cyc;
        push_take(t + 3, 5'd3, 1'b0);
        idle(2);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(1);
        #3;
        chk("eret_sync_stays_exl", exl, 1);
        do_eret();

        // T3: interrupt waits on empty pipe, then beats code 12 in M
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("int_bubble_no_take", exc_take, 0);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        t = cyc;
        push_take(t + 3, 5'd0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        #3;
        chk("t3_exl", exl, 1);

        // T4: interrupt ignored in EXL, then ERET returns
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        t = cyc;
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("t4_int_in_exl_no_take", exc_take, 0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        push_eret(t + 4);
        idle(1);
        #3;
        chk("t4_exl_cleared", exl, 0);
        chk("t4_redirect_done", redirect, 0);

        // T5a: ERET in RUN -> reserved-instruction code 10
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        t = cyc;
        push_take(t + 3, 5'd10, 1'b1);
        idle(2);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(1);
        #3;
        chk("t5_exl", exl, 1);
        do_eret();

        // T5b: two stall cycles with exc_D=5 delay the commit by 2
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        t = cyc;
        push_take(t + 5, 5'd5, 1'b1);
        step(1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
        idle(1);
        #3;
        chk("t5b_exl", exl, 1);

        // T6: reset the cycle before a pending take (from EXL)
        step(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #3;
        chk("t6_exc_take", exc_take, 0);
        chk("t6_flush", flush, 0);
        chk("t6_exl", exl, 0);
        idle(4);

        idle(2);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
